// File: rtl/vram_text_scan.sv
// vram_text_scan: video-side scanner for a 64x32 character text buffer.
// Counts pixels/lines, fetches characters from VRAM, looks up glyph rows in
// a synchronous font ROM and serialises them MSB-first into a mono pixel
// stream with de/hsync/vsync/frame_start. Every output lags the counters by
// three clocks.
// Optional build macro: VRAM_TEXT_SCAN_CURSOR_EN (blinking underline cursor).
module vram_text_scan #(
    parameter int unsigned H_ACTIVE = 512,
    parameter int unsigned H_FP     = 80,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 112,
    parameter int unsigned V_ACTIVE = 256,
    parameter int unsigned V_FP     = 122,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 145,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  scroll_row,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_q,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_q,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VRAM_TEXT_SCAN_CURSOR_EN
    ,
    input  logic [10:0] cursor_pos,
    input  logic        cursor_on
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [4:0]  scroll_q, scroll_d;
    logic [10:0] addr_hold_q, addr_hold_d;
    logic [2:0]  vline1_q, vline1_d;
    logic [2:0]  de_p_q, de_p_d;
    logic [2:0]  hs_p_q, hs_p_d;
    logic [2:0]  vs_p_q, vs_p_d;
    logic [2:0]  fs_p_q, fs_p_d;
    logic [1:0]  ld_p_q, ld_p_d;
    logic [7:0]  shift_q, shift_d;

    logic        frame_origin;
    logic        line_last;
    logic        frame_last;
    logic        active;
    logic        load0;
    logic        hs_raw;
    logic        vs_raw;
    logic [4:0]  scroll_eff;
    logic [4:0]  text_row;
    logic [7:0]  glyph;

`ifdef VRAM_TEXT_SCAN_CURSOR_EN
    logic [4:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  cur_p_q, cur_p_d;
    logic        cur_hit0;
`endif

    // Raster counters: hcnt wraps every line, vcnt advances on each hcnt wrap.
    always_comb begin
        line_last  = (hcnt_q == H_LAST);
        frame_last = line_last && (vcnt_q == V_LAST);
        hcnt_d     = hcnt_q + 10'd1;
        vcnt_d     = vcnt_q;
        if (line_last) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    // Stage 0: scroll latch, active window, VRAM address and raw sync timing.
    always_comb begin
        frame_origin = (hcnt_q == '0) && (vcnt_q == '0);
        // The origin cycle already fetches with the freshly sampled scroll so
        // the whole frame, including its first cell, uses one scroll value.
        scroll_eff   = frame_origin ? scroll_row : scroll_q;
        scroll_d     = scroll_eff;
        active       = (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L);
        text_row     = vcnt_q[7:3] + scroll_eff;
        vram_addr    = active ? {text_row, hcnt_q[8:3]} : addr_hold_q;
        addr_hold_d  = vram_addr;
        load0        = active && (hcnt_q[2:0] == 3'd0);
        hs_raw       = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        vs_raw       = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    end

    // Stages 1..3: font address, alignment pipelines and the pixel shifter.
    always_comb begin
        vline1_d  = vcnt_q[2:0];
        font_addr = {vram_q, vline1_q};
        de_p_d    = {de_p_q[1:0], active};
        hs_p_d    = {hs_p_q[1:0], hs_raw};
        vs_p_d    = {vs_p_q[1:0], vs_raw};
        fs_p_d    = {fs_p_q[1:0], frame_origin};
        ld_p_d    = {ld_p_q[0], load0};
        glyph     = font_q;
`ifdef VRAM_TEXT_SCAN_CURSOR_EN
        cur_hit0    = active && cursor_on && (vcnt_q[2:1] == 2'b11) &&
                      ({vcnt_q[7:3], hcnt_q[8:3]} == cursor_pos);
        cur_p_d     = {cur_p_q[0], cur_hit0};
        // Advances as each new frame begins, so frame N after reset sees N.
        frame_cnt_d = frame_last ? frame_cnt_q + 5'd1 : frame_cnt_q;
        if (cur_p_q[1] && frame_cnt_q[4]) begin
            glyph = '1;
        end
`endif
        if (ld_p_q[1]) begin
            shift_d = de_p_q[1] ? glyph : '0;
        end else begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    // Output decode from the third pipeline stage.
    always_comb begin
        de          = de_p_q[2];
        pixel       = shift_q[7] && de_p_q[2];
        hsync       = hs_p_q[2] ? SYNC_POL : ~SYNC_POL;
        vsync       = vs_p_q[2] ? SYNC_POL : ~SYNC_POL;
        frame_start = fs_p_q[2];
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            scroll_q    <= '0;
            addr_hold_q <= '0;
            vline1_q    <= '0;
            de_p_q      <= '0;
            hs_p_q      <= '0;
            vs_p_q      <= '0;
            fs_p_q      <= '0;
            ld_p_q      <= '0;
            shift_q     <= '0;
`ifdef VRAM_TEXT_SCAN_CURSOR_EN
            frame_cnt_q <= '0;
            cur_p_q     <= '0;
`endif
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            scroll_q    <= scroll_d;
            addr_hold_q <= addr_hold_d;
            vline1_q    <= vline1_d;
            de_p_q      <= de_p_d;
            hs_p_q      <= hs_p_d;
            vs_p_q      <= vs_p_d;
            fs_p_q      <= fs_p_d;
            ld_p_q      <= ld_p_d;
            shift_q     <= shift_d;
`ifdef VRAM_TEXT_SCAN_CURSOR_EN
            frame_cnt_q <= frame_cnt_d;
            cur_p_q     <= cur_p_d;
`endif
        end
    end

endmodule
